// File: rtl/dilithium_stream_adapter_if.sv
//============================================================================
// Module      : dilithium_stream_adapter_if
// Description : Bundle of the control, core-side and host-side stream
//               signals of dilithium_stream_adapter.
//               master modport : the adapter (drives host beats and status)
//               slave modport  : the environment (core, host, controller)
//               Ports: start/mode/sec_lvl control, core_valid/core_ready/
//               core_data (64-bit core stream), valid_o/ready_o/data_o/last
//               (OUT_W-bit host stream), busy/done/err status, and keep_o
//               when DILITHIUM_ADAPTER_KEEP_EN is defined.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface dilithium_stream_adapter_if #(
    parameter int OUT_W = 64
);
    logic             start;
    logic [1:0]       mode;
    logic [2:0]       sec_lvl;
    logic             core_valid;
    logic             core_ready;
    logic [63:0]      core_data;
    logic             valid_o;
    logic             ready_o;
    logic [OUT_W-1:0] data_o;
    logic             last;
    logic             busy;
    logic             done;
    logic             err;
`ifdef DILITHIUM_ADAPTER_KEEP_EN
    logic [OUT_W/8-1:0] keep_o;

    modport master (
        input  start, mode, sec_lvl, core_valid, core_data, ready_o,
        output core_ready, valid_o, data_o, last, busy, done, err, keep_o
    );
    modport slave (
        output start, mode, sec_lvl, core_valid, core_data, ready_o,
        input  core_ready, valid_o, data_o, last, busy, done, err, keep_o
    );
`else
    modport master (
        input  start, mode, sec_lvl, core_valid, core_data, ready_o,
        output core_ready, valid_o, data_o, last, busy, done, err
    );
    modport slave (
        output start, mode, sec_lvl, core_valid, core_data, ready_o,
        input  core_ready, valid_o, data_o, last, busy, done, err
    );
`endif
endinterface

`default_nettype wire

// File: rtl/dilithium_stream_adapter.sv
//============================================================================
// Module      : dilithium_stream_adapter
// Description : Output adapter between the Dilithium core (64-bit words)
//               and the host stream bus (OUT_W-bit beats). A rising edge on
//               start loads the per-operation core-word count; each core
//               word is held in one buffer and emitted LSB slice first.
//               last marks the final beat, done/err are one-cycle pulses.
// Ports       : clk, rst_n (async, active-low),
//               bus (dilithium_stream_adapter_if.master) - see interface.
// Parameters  : OUT_W (16/32/64 host width), CNT_W (core-word counter).
// Options     : DILITHIUM_ADAPTER_KEEP_EN - adds keep_o and trims sign
//               outputs to their exact byte length.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module dilithium_stream_adapter #(
    parameter int OUT_W = 64,
    parameter int CNT_W = 12
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    dilithium_stream_adapter_if.master   bus
);
    localparam int R  = 64 / OUT_W;
    localparam int SW = (R > 1) ? $clog2(R) : 1;
    localparam int BB = OUT_W / 8;
    localparam int BW = CNT_W + 3;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [SW-1:0] c_last_slice = SW'(R - 1);

    logic [0:0]       r_state;
    logic             r_start_q;
    logic [63:0]      r_buf;
    logic             r_full;
    logic [SW-1:0]    r_slice;
    logic [CNT_W-1:0] r_taken;
    logic [CNT_W-1:0] r_n;
    logic             r_done;
    logic             r_err;

    logic w_strobe, w_legal, w_last_slice, w_hs, w_take, w_last, w_core_ready;

    function automatic logic [CNT_W-1:0] f_words(input logic [1:0] m, input logic [2:0] s);
        logic [CNT_W-1:0] n;
        n = '0;
        case (m)
            2'd0: case (s)
                3'd2:    n = CNT_W'(484);
                3'd3:    n = CNT_W'(748);
                3'd5:    n = CNT_W'(936);
                default: n = '0;
            endcase
            2'd1:    n = CNT_W'(1);
            2'd2: case (s)
                3'd2:    n = CNT_W'(303);
                3'd3:    n = CNT_W'(414);
                3'd5:    n = CNT_W'(579);
                default: n = '0;
            endcase
            default: n = '0;
        endcase
        return n;
    endfunction

    assign w_strobe     = bus.start & ~r_start_q;
    assign w_legal      = (bus.mode != 2'd3) &&
                          (bus.sec_lvl == 3'd2 || bus.sec_lvl == 3'd3 || bus.sec_lvl == 3'd5);
    assign w_last_slice = (r_slice == c_last_slice);
    assign w_hs         = r_full & bus.ready_o;
    // A new word may enter only when the buffer is empty or its final slice
    // leaves this very cycle, which keeps the host stream bubble-free.
    assign w_core_ready = (r_state == S_RUN) && (r_taken < r_n) &&
                          (!r_full || (w_hs && w_last_slice));
    assign w_take       = bus.core_valid & w_core_ready;

`ifdef DILITHIUM_ADAPTER_KEEP_EN
    // Bytes still owed to the host, including the beat currently presented.
    logic [BW-1:0] r_bytes_left;

    function automatic logic [BW-1:0] f_bytes(input logic [1:0] m, input logic [2:0] s);
        logic [BW-1:0] b;
        if (m == 2'd2) begin
            case (s)
                3'd2:    b = BW'(2420);
                3'd3:    b = BW'(3309);
                3'd5:    b = BW'(4627);
                default: b = '0;
            endcase
        end else begin
            b = {f_words(m, s), 3'b000};
        end
        return b;
    endfunction

    // Ending on the byte count drops any slices wholly past the payload.
    assign w_last = r_full && (r_bytes_left <= BW'(BB));

    always_comb begin
        bus.keep_o = '0;
        for (int i = 0; i < BB; i++) begin
            bus.keep_o[i] = r_full && (r_bytes_left > BW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bytes_left <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_strobe && w_legal) begin
                r_bytes_left <= f_bytes(bus.mode, bus.sec_lvl);
            end
        end else if (w_hs) begin
            r_bytes_left <= r_bytes_left - BW'(BB);
        end
    end
`else
    // The buffer always holds word number r_taken, so the final beat is the
    // last slice of the word that brought r_taken up to r_n.
    assign w_last = r_full && w_last_slice && (r_taken == r_n);
`endif

    generate
        if (R == 1) begin : g_full_width
            assign bus.data_o = r_buf;
        end else begin : g_narrow
            assign bus.data_o = r_buf[32'(r_slice) * OUT_W +: OUT_W];
        end
    endgenerate

    assign bus.core_ready = w_core_ready;
    assign bus.valid_o    = r_full;
    assign bus.last       = w_last;
    assign bus.busy       = (r_state == S_RUN);
    assign bus.done       = r_done;
    assign bus.err        = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b0;
            r_buf     <= '0;
            r_full    <= 1'b0;
            r_slice   <= '0;
            r_taken   <= '0;
            r_n       <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_start_q <= bus.start;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_strobe) begin
                        if (w_legal) begin
                            r_state <= S_RUN;
                            r_n     <= f_words(bus.mode, bus.sec_lvl);
                            r_taken <= '0;
                            r_full  <= 1'b0;
                            r_slice <= '0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_hs && w_last) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_full  <= 1'b0;
                        r_slice <= '0;
                    end else if (w_take) begin
                        r_buf   <= bus.core_data;
                        r_full  <= 1'b1;
                        r_slice <= '0;
                        r_taken <= r_taken + CNT_W'(1);
                    end else if (w_hs) begin
                        if (w_last_slice) begin
                            r_full  <= 1'b0;
                            r_slice <= '0;
                        end else begin
                            r_slice <= r_slice + SW'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire
